// File: rtl/arctan_10_9.sv
// arctan_10_9: 4-stage pipelined binary32 atan(x) in degrees, quantised to Q10.9 before repacking.
// Define ARCTAN_10_9_SPECIALS_EN to decode exponent 255 (NaN/Inf) and override the packed result.
module arctan_10_9 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] num_entrada,
  output logic [31:0] num_salida
);

  typedef struct packed {
    logic signed [28:0] x;
    logic signed [28:0] y;
    logic signed [31:0] z;
  } cordic_t;

  typedef struct packed {
`ifdef ARCTAN_10_9_SPECIALS_EN
    logic nan;
    logic inf;
`endif
    logic sgn;
  } tag_t;

  localparam logic [26:0]        ONE_V   = 27'd8388608;
  localparam logic signed [31:0] FULL_90 = 32'sd94371840;

  // atan(2^-i) in degrees, 20 fractional bits
  function automatic logic signed [31:0] atan_tab(input int unsigned i);
    case (i)
      0:       return 32'sd47185920;
      1:       return 32'sd27855475;
      2:       return 32'sd14718068;
      3:       return 32'sd7471121;
      4:       return 32'sd3750058;
      5:       return 32'sd1876857;
      6:       return 32'sd938658;
      7:       return 32'sd469357;
      8:       return 32'sd234682;
      9:       return 32'sd117342;
      10:      return 32'sd58671;
      11:      return 32'sd29335;
      12:      return 32'sd14668;
      13:      return 32'sd7334;
      14:      return 32'sd3667;
      15:      return 32'sd1833;
      16:      return 32'sd917;
      17:      return 32'sd458;
      18:      return 32'sd229;
      default: return 32'sd115;
    endcase
  endfunction

  function automatic cordic_t cordic_step(input cordic_t v, input int unsigned i);
    logic signed [28:0] x, y, xs, ys;
    logic signed [31:0] z;
    cordic_t r;
    x  = v.x;
    y  = v.y;
    z  = v.z;
    xs = x >>> i;
    ys = y >>> i;
    if (!y[28]) begin
      r.x = x + ys;
      r.y = y - xs;
      r.z = z + atan_tab(i);
    end else begin
      r.x = x - ys;
      r.y = y + xs;
      r.z = z - atan_tab(i);
    end
    return r;
  endfunction

  function automatic cordic_t cordic_half(input cordic_t v_in, input int unsigned first);
    cordic_t v;
    v = v_in;
    for (int unsigned k = 0; k < 10; k++) v = cordic_step(v, first + k);
    return v;
  endfunction

  function automatic logic signed [31:0] cordic_tail_z(input cordic_t v_in, input int unsigned first);
    cordic_t v;
    v = v_in;
    for (int unsigned k = 0; k < 10; k++) v = cordic_step(v, first + k);
    return v.z;
  endfunction

  // Reset leaves every stage holding exactly what an input of 0.0 would produce.
  localparam cordic_t            S2_RST   = cordic_half({29'sd8388608, 29'sd0, 32'sd0}, 0);
  localparam logic signed [31:0] S3_RST_Z = cordic_tail_z(S2_RST, 10);

  logic [26:0]        s1_x_d, s1_x_q, s1_y_d, s1_y_q;
  logic               s1_fold_d, s1_fold_q;
  tag_t               s1_tag_d, s1_tag_q;
  cordic_t            s2_in, s2_v_d, s2_v_q;
  logic               s2_fold_q;
  tag_t               s2_tag_q;
  logic signed [31:0] s3_z_d, s3_z_q;
  tag_t               s3_tag_q;
  logic [31:0]        num_salida_d, num_salida_q;

  logic [7:0]  s1_exp, s1_sh;
  logic [23:0] s1_man;

  always_comb begin
    s1_exp       = num_entrada[30:23];
    s1_man       = {1'b1, num_entrada[22:0]};
    s1_sh        = '0;
    s1_x_d       = ONE_V;
    s1_y_d       = '0;
    s1_fold_d    = 1'b0;
    s1_tag_d     = '0;
    s1_tag_d.sgn = num_entrada[31];
    if (s1_exp == 8'd0) begin
      s1_x_d = ONE_V;
    end else if (s1_exp < 8'd127) begin
      s1_sh  = 8'd127 - s1_exp;
      s1_y_d = (s1_sh >= 8'd27) ? '0 : ({3'b000, s1_man} >> s1_sh);
    end else begin
      // |x| >= 1: vector (x, 1) gives atan(1/x), folded back from 90 in S3
      s1_sh     = s1_exp - 8'd127;
      s1_x_d    = {3'b000, s1_man};
      s1_y_d    = (s1_sh >= 8'd27) ? '0 : (ONE_V >> s1_sh);
      s1_fold_d = 1'b1;
    end
`ifdef ARCTAN_10_9_SPECIALS_EN
    s1_tag_d.nan = (s1_exp == 8'hFF) && (num_entrada[22:0] != 23'd0);
    s1_tag_d.inf = (s1_exp == 8'hFF) && (num_entrada[22:0] == 23'd0);
`endif
  end

  always_comb begin
    s2_in.x = signed'({2'b00, s1_x_q});
    s2_in.y = signed'({2'b00, s1_y_q});
    s2_in.z = '0;
    s2_v_d  = cordic_half(s2_in, 0);
  end

  always_comb begin
    s3_z_d = cordic_tail_z(s2_v_q, 10);
    if (s2_fold_q) s3_z_d = FULL_90 - s3_z_d;
  end

  logic        s4_neg;
  logic [31:0] s4_mag;
  logic [18:0] s4_q;
  logic [4:0]  s4_lead;
  logic [22:0] s4_frac;
  logic [7:0]  s4_exp;

  always_comb begin
    s4_neg  = s3_z_q[31];
    s4_mag  = s4_neg ? 32'(-s3_z_q) : 32'(s3_z_q);
    // round half away from zero on the magnitude: 20 -> 9 fractional bits
    s4_q    = 19'((s4_mag + 32'd1024) >> 11);
    s4_lead = '0;
    for (int unsigned b = 0; b < 19; b++) begin
      if (s4_q[b]) s4_lead = 5'(b);
    end
    s4_frac = 23'(32'(s4_q) << (5'd23 - s4_lead));
    s4_exp  = 8'd118 + 8'(s4_lead);
    num_salida_d = (s4_q == 19'd0) ? '0 : {s3_tag_q.sgn ^ s4_neg, s4_exp, s4_frac};
`ifdef ARCTAN_10_9_SPECIALS_EN
    if (s3_tag_q.nan) num_salida_d = 32'h7FC00000;
    else if (s3_tag_q.inf) num_salida_d = s3_tag_q.sgn ? 32'hC2B40000 : 32'h42B40000;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_x_q       <= ONE_V;
      s1_y_q       <= '0;
      s1_fold_q    <= 1'b0;
      s1_tag_q     <= '0;
      s2_v_q       <= S2_RST;
      s2_fold_q    <= 1'b0;
      s2_tag_q     <= '0;
      s3_z_q       <= S3_RST_Z;
      s3_tag_q     <= '0;
      num_salida_q <= '0;
    end else if (enable) begin
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_fold_q    <= s1_fold_d;
      s1_tag_q     <= s1_tag_d;
      s2_v_q       <= s2_v_d;
      s2_fold_q    <= s1_fold_q;
      s2_tag_q     <= s1_tag_q;
      s3_z_q       <= s3_z_d;
      s3_tag_q     <= s2_tag_q;
      num_salida_q <= num_salida_d;
    end
  end

  assign num_salida = num_salida_q;

endmodule

// File: tb/tb_arctan_10_9.sv
// Scoreboard bench for arctan_10_9: expected results are queued at issue time and
// checked by an independent monitor against a real-valued atan reference.
module tb_arctan_10_9;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] num_entrada;
  logic [31:0] num_salida;

  always #5 clk = ~clk;

  arctan_10_9 dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .num_entrada(num_entrada),
    .num_salida (num_salida)
  );

  typedef struct {
    logic [31:0]    x;
    logic [31:0]    want;
    bit             exact;
    int unsigned    due;
    logic [8*12-1:0] name;
  } exp_t;

  localparam real PI  = 3.14159265358979323846;
  localparam real LSB = 1.0 / 512.0;

  exp_t        sb[$];
  int unsigned en_cnt = 0;
  int          total = 0;
  int          bad = 0;

  logic [31:0] fx_in   [6] = '{32'h00000000, 32'h3F800000, 32'hBF800000,
                               32'h7149F2CA, 32'h80000000, 32'h00000001};
  logic [31:0] fx_want [6] = '{32'h00000000, 32'h42340000, 32'hC2340000,
                               32'h42B40000, 32'h00000000, 32'h00000000};
  logic [31:0] edge_in [9] = '{32'h3F7FFFFF, 32'h3F800001, 32'h4B800000,
                               32'h33800000, 32'h7F7FFFFF, 32'hFF7FFFFF,
                               32'h7F800000, 32'hFF800000, 32'h7FC00001};

  function automatic real ref_deg(input logic [31:0] xb);
    return $atan($bitstoshortreal(xb)) * 180.0 / PI;
  endfunction

  // Queue the expectation for operand xb, drive it, and move to the next negedge.
  task automatic issue(input logic [31:0] xb, input logic [8*12-1:0] name);
    exp_t e;
    e.x     = xb;
    e.name  = name;
    e.due   = en_cnt + 4;
    e.exact = 1'b1;
    e.want  = '0;
    if (xb[30:23] == 8'hFF) begin
`ifdef ARCTAN_10_9_SPECIALS_EN
      if (xb[22:0] != 23'd0) e.want = 32'h7FC00000;
      else e.want = xb[31] ? 32'hC2B40000 : 32'h42B40000;
`else
      e.want = xb[31] ? 32'hC2B40000 : 32'h42B40000;
`endif
    end else if (xb[30:23] == 8'h00) begin
      e.want = '0;
    end else begin
      e.exact = 1'b0;
    end
    sb.push_back(e);
    num_entrada = xb;
    enable      = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue_exact(input logic [31:0] xb, input logic [31:0] want, input logic [8*12-1:0] name);
    exp_t e;
    e.x     = xb;
    e.want  = want;
    e.exact = 1'b1;
    e.due   = en_cnt + 4;
    e.name  = name;
    sb.push_back(e);
    num_entrada = xb;
    enable      = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    enable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // After reset release the next three enabled edges must still show +0.
  task automatic zero_window();
    exp_t e;
    for (int unsigned k = 1; k <= 3; k++) begin
      e.x     = '0;
      e.want  = '0;
      e.exact = 1'b1;
      e.due   = en_cnt + k;
      e.name  = "post_rst";
      sb.push_back(e);
    end
  endtask

  task automatic do_reset(input logic [8*12-1:0] name);
    reset  = 1'b1;
    enable = 1'b0;
    sb.delete();
    #1;
    total++;
    if (num_salida !== 32'h00000000) begin
      bad++;
      $display("FAIL %0s got=%h want=00000000", name, num_salida);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    zero_window();
  endtask

  // Monitor: counts enabled edges, checks holds while stalled, pops due expectations.
  initial begin
    logic        e_s, r_s;
    logic [31:0] prev_out;
    bit          prev_valid;
    exp_t        c;
    real         got, rv, err;
    prev_valid = 1'b0;
    prev_out   = '0;
    forever begin
      @(posedge clk);
      e_s = enable;
      r_s = reset;
      if (e_s && !r_s) en_cnt++;
      #1;
      if (r_s || reset) begin
        prev_valid = 1'b0;
      end else begin
        if (!e_s && prev_valid) begin
          total++;
          if (num_salida !== prev_out) begin
            bad++;
            $display("FAIL hold got=%h want=%h", num_salida, prev_out);
          end
        end
        while (sb.size() > 0 && sb[0].due <= en_cnt) begin
          c = sb.pop_front();
          total++;
          if (c.due != en_cnt) begin
            bad++;
            $display("FAIL %0s late x=%h due=%0d at=%0d", c.name, c.x, c.due, en_cnt);
          end else if (c.exact) begin
            if (num_salida !== c.want) begin
              bad++;
              $display("FAIL %0s x=%h got=%h want=%h", c.name, c.x, num_salida, c.want);
            end
          end else begin
            got = $bitstoshortreal(num_salida);
            rv  = ref_deg(c.x);
            err = got - rv;
            if (err < 0.0) err = -err;
            // Q10.9 rounding contributes up to half an LSB; CORDIC residue stays well below a quarter
            if (num_salida[30:23] == 8'hFF || err > 0.75 * LSB) begin
              bad++;
              $display("FAIL %0s x=%h got=%h (%.6f) want=%.6f err=%.6f", c.name, c.x, num_salida, got, rv, err);
            end
          end
        end
        prev_out   = num_salida;
        prev_valid = 1'b1;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    num_entrada = '0;
    repeat (2) @(negedge clk);
    total++;
    if (num_salida !== 32'h00000000) begin
      bad++;
      $display("FAIL reset_state got=%h want=00000000", num_salida);
    end
    reset = 1'b0;
    zero_window();

    for (int i = 0; i < 6; i++) issue_exact(fx_in[i], fx_want[i], "fixed");
    for (int i = 0; i < 9; i++) issue(edge_in[i], "edge");

    for (int n = 0; n < 300; n++) issue($shortrealtobits(-2000.0 + 0.01 * n), "sweep_far");
    for (int n = 0; n <= 600; n++) issue($shortrealtobits(-3.0 + 0.01 * n), "sweep_mid");

    issue(32'h3F000000, "stall_05");
    issue(32'h40000000, "stall_20");
    idle(5);
    repeat (4) issue(32'h00000000, "stall_tail");

    for (int n = 0; n < 600; n++) begin
      logic [31:0] b;
      b = $urandom;
      issue(b, "rand_bits");
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    for (int n = 0; n < 400; n++) begin
      real r;
      r = (real'($urandom_range(0, 400000)) - 200000.0) / 100.0;
      issue($shortrealtobits(r), "rand_range");
    end

    repeat (5) issue(32'h3F800000, "pre_rst");
    do_reset("rst_async");
    for (int n = 0; n < 20; n++) issue($urandom, "post_rand");

    enable      = 1'b1;
    num_entrada = '0;
    repeat (6) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
